// File: rtl/fantasticfft_fft8_pipe.sv
// fantasticfft_fft8_pipe: streaming 8-point radix-2 DIT FFT/IFFT, one frame per cycle, 4 register stages
module fantasticfft_fft8_pipe #(
    parameter int DATA_W  = 8,
    parameter int TW_FRAC = 8,
    parameter int OUT_W   = DATA_W + 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*DATA_W-1:0]  x_re,
    input  logic [8*DATA_W-1:0]  x_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   y_re,
    output logic [8*OUT_W-1:0]   y_im,
    output logic                 out_inv
);
    localparam int C  = $rtoi(0.70710678 * $itor(1 << TW_FRAC) + 0.5);
    localparam int SW = OUT_W + 1;
    localparam int PW = OUT_W + TW_FRAC + 3;
    localparam logic signed [PW-1:0] CP  = PW'(C);
    localparam logic signed [PW-1:0] RND = PW'(1 << (TW_FRAC - 1));

    function automatic logic signed [OUT_W-1:0] tw(input logic signed [SW-1:0] s);
        logic signed [PW-1:0] p;
        p = PW'(s) * CP + RND;
        return OUT_W'(p >>> TW_FRAC);
    endfunction

    logic en, v1, v2, v3, inv1, inv2, inv3;
    logic signed [OUT_W-1:0] xr [8], xi [8];
    logic signed [OUT_W-1:0] n1_re [8], n1_im [8], s1_re [8], s1_im [8];
    logic signed [OUT_W-1:0] n2_re [8], n2_im [8], s2_re [8], s2_im [8];
    logic signed [OUT_W-1:0] n3_re [8], n3_im [8], s3_re [8], s3_im [8];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // sign-extend the packed input samples to the full output width
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            xr[i] = OUT_W'($signed(x_re[i*DATA_W +: DATA_W]));
            xi[i] = OUT_W'($signed(x_im[i*DATA_W +: DATA_W]));
        end
    end

    // stage 1: 2-point butterflies on (x0,x4),(x2,x6),(x1,x5),(x3,x7), stored as sum/diff pairs
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            n1_re[2*j]   = xr[(j % 2) * 2 + j / 2] + xr[(j % 2) * 2 + j / 2 + 4];
            n1_im[2*j]   = xi[(j % 2) * 2 + j / 2] + xi[(j % 2) * 2 + j / 2 + 4];
            n1_re[2*j+1] = xr[(j % 2) * 2 + j / 2] - xr[(j % 2) * 2 + j / 2 + 4];
            n1_im[2*j+1] = xi[(j % 2) * 2 + j / 2] - xi[(j % 2) * 2 + j / 2 + 4];
        end
    end

    // stage 2: 4-point combine of even (slots 0-3) and odd (slots 4-7) sets; W4 is a swap/negate
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            n2_re[4*g]   = s1_re[4*g] + s1_re[4*g+2];
            n2_im[4*g]   = s1_im[4*g] + s1_im[4*g+2];
            n2_re[4*g+2] = s1_re[4*g] - s1_re[4*g+2];
            n2_im[4*g+2] = s1_im[4*g] - s1_im[4*g+2];
            n2_re[4*g+1] = s1_re[4*g+1] + (inv1 ? -s1_im[4*g+3] : s1_im[4*g+3]);
            n2_im[4*g+1] = s1_im[4*g+1] + (inv1 ? s1_re[4*g+3] : -s1_re[4*g+3]);
            n2_re[4*g+3] = s1_re[4*g+1] - (inv1 ? -s1_im[4*g+3] : s1_im[4*g+3]);
            n2_im[4*g+3] = s1_im[4*g+1] - (inv1 ? s1_re[4*g+3] : -s1_re[4*g+3]);
        end
    end

    // stage 3: odd bins times W8^k; k=1,3 need one rounded C-product per component
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            n3_re[i] = s2_re[i];
            n3_im[i] = s2_im[i];
        end
        n3_re[5] = tw(inv2 ? SW'(s2_re[5]) - SW'(s2_im[5]) : SW'(s2_re[5]) + SW'(s2_im[5]));
        n3_im[5] = tw(inv2 ? SW'(s2_re[5]) + SW'(s2_im[5]) : SW'(s2_im[5]) - SW'(s2_re[5]));
        n3_re[6] = inv2 ? -s2_im[6] : s2_im[6];
        n3_im[6] = inv2 ? s2_re[6] : -s2_re[6];
        n3_re[7] = tw(inv2 ? -SW'(s2_re[7]) - SW'(s2_im[7]) : SW'(s2_im[7]) - SW'(s2_re[7]));
        n3_im[7] = tw(inv2 ? SW'(s2_re[7]) - SW'(s2_im[7]) : -SW'(s2_re[7]) - SW'(s2_im[7]));
    end

    // pipeline registers; everything advances together only while the output can move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1, v2, v3, out_valid, inv1, inv2, inv3, out_inv} <= '0;
            s1_re <= '{default: '0};
            s1_im <= '{default: '0};
            s2_re <= '{default: '0};
            s2_im <= '{default: '0};
            s3_re <= '{default: '0};
            s3_im <= '{default: '0};
            y_re  <= '0;
            y_im  <= '0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            inv1      <= in_inv;
            inv2      <= inv1;
            inv3      <= inv2;
            out_inv   <= inv3;
            s1_re     <= n1_re;
            s1_im     <= n1_im;
            s2_re     <= n2_re;
            s2_im     <= n2_im;
            s3_re     <= n3_re;
            s3_im     <= n3_im;
            for (int k = 0; k < 4; k++) begin
                y_re[k*OUT_W +: OUT_W]     <= s3_re[k] + s3_re[k+4];
                y_im[k*OUT_W +: OUT_W]     <= s3_im[k] + s3_im[k+4];
                y_re[(k+4)*OUT_W +: OUT_W] <= s3_re[k] - s3_re[k+4];
                y_im[(k+4)*OUT_W +: OUT_W] <= s3_im[k] - s3_im[k+4];
            end
        end
    end
endmodule

// File: tb/tb_fantasticfft_fft8_pipe.sv
// tb_fantasticfft_fft8_pipe: directed and streaming checks of the pipelined 8-point FFT core
module tb_fantasticfft_fft8_pipe;
    localparam int OW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
    logic [63:0] x_re, x_im;
    logic [8*OW-1:0] y_re, y_im;
    int checks = 0;
    int failures = 0;
    logic [192:0] q[$];

    always #5 clk = ~clk;

    fantasticfft_fft8_pipe #(.DATA_W(8), .TW_FRAC(8), .OUT_W(OW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .x_re(x_re), .x_im(x_im), .out_valid(out_valid), .out_ready(out_ready),
        .y_re(y_re), .y_im(y_im), .out_inv(out_inv)
    );

    function automatic logic [63:0] jrot(input int a, input int b, input int qq);
        case (qq)
            0: return {a, b};
            1: return {-b, a};
            2: return {-a, -b};
            default: return {b, -a};
        endcase
    endfunction

    // golden model: direct 4-point DFTs, then rounded complex twiddle, then final butterfly
    function automatic logic [192:0] model(input logic [63:0] xr, input logic [63:0] xi, input logic inv);
        int rv[8], iv[8];
        int er, ei, orr, oi, pr, pi, tr, ti, sr, si, qq;
        logic [63:0] v;
        logic [95:0] yr, yi;
        yr = '0;
        yi = '0;
        for (int n = 0; n < 8; n++) begin
            rv[n] = $signed(xr[n*8 +: 8]);
            iv[n] = $signed(xi[n*8 +: 8]);
        end
        for (int k = 0; k < 4; k++) begin
            er = 0; ei = 0; orr = 0; oi = 0;
            for (int n = 0; n < 4; n++) begin
                qq = inv ? (n * k) % 4 : (3 * n * k) % 4;
                v = jrot(rv[2*n], iv[2*n], qq);
                er += $signed(v[63:32]);
                ei += $signed(v[31:0]);
                v = jrot(rv[2*n+1], iv[2*n+1], qq);
                orr += $signed(v[63:32]);
                oi += $signed(v[31:0]);
            end
            if (k == 0) begin
                pr = orr; pi = oi;
            end else if (k == 2) begin
                v = jrot(orr, oi, inv ? 1 : 3);
                pr = $signed(v[63:32]);
                pi = $signed(v[31:0]);
            end else begin
                sr = (k == 1) ? 1 : -1;
                si = inv ? 1 : -1;
                tr = orr * sr - oi * si;
                ti = orr * si + oi * sr;
                pr = (181 * tr + 128) >>> 8;
                pi = (181 * ti + 128) >>> 8;
            end
            yr[k*12 +: 12]     = 12'(er + pr);
            yi[k*12 +: 12]     = 12'(ei + pi);
            yr[(k+4)*12 +: 12] = 12'(er - pr);
            yi[(k+4)*12 +: 12] = 12'(ei - pi);
        end
        return {inv, yi, yr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drives one frame for one cycle and returns the number of edges (accept edge = 1) until out_valid
    task automatic send_one(input logic [63:0] xr, input logic [63:0] xi, input logic inv, output int lat);
        x_re = xr; x_im = xi; in_inv = inv; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (y_re !== '0) begin failures++; $display("FAIL reset_y_re got %h exp 0", y_re); end
        checks++; if (y_im !== '0) begin failures++; $display("FAIL reset_y_im got %h exp 0", y_im); end
        checks++; if (out_inv !== 1'b0) begin failures++; $display("FAIL reset_out_inv got %b exp 0", out_inv); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_impulse();
        int lat;
        send_one(64'd100, 64'd0, 1'b0, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL impulse_latency got %0d exp 4", lat); end
        checks++; if (y_re !== {8{12'd100}}) begin failures++; $display("FAIL impulse_re got %h exp %h", y_re, {8{12'd100}}); end
        checks++; if (y_im !== '0) begin failures++; $display("FAIL impulse_im got %h exp 0", y_im); end
        checks++; if (out_inv !== 1'b0) begin failures++; $display("FAIL impulse_out_inv got %b exp 0", out_inv); end
    endtask

    task automatic test_dc();
        int lat;
        send_one({8{8'd10}}, 64'd0, 1'b0, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL dc_latency got %0d exp 4", lat); end
        checks++; if (y_re !== {84'd0, 12'd80}) begin failures++; $display("FAIL dc_re got %h exp %h", y_re, {84'd0, 12'd80}); end
        checks++; if (y_im !== '0) begin failures++; $display("FAIL dc_im got %h exp 0", y_im); end
        send_one({8{8'h80}}, 64'd0, 1'b0, lat);
        checks++; if (y_re !== {84'd0, 12'hC00}) begin failures++; $display("FAIL maxneg_re got %h exp %h", y_re, {84'd0, 12'hC00}); end
        checks++; if (y_im !== '0) begin failures++; $display("FAIL maxneg_im got %h exp 0", y_im); end
    endtask

    task automatic test_shifted_impulse();
        int lat;
        int fre[8] = '{64, 45, 0, -45, -64, -45, 0, 45};
        int fim[8] = '{0, -45, -64, -45, 0, 45, 64, 45};
        logic [95:0] er, ei, eim_inv;
        for (int k = 0; k < 8; k++) begin
            er[k*12 +: 12]      = 12'(fre[k]);
            ei[k*12 +: 12]      = 12'(fim[k]);
            eim_inv[k*12 +: 12] = 12'(-fim[k]);
        end
        send_one(64'd64 << 8, 64'd0, 1'b0, lat);
        checks++; if (y_re !== er) begin failures++; $display("FAIL shift_fwd_re got %h exp %h", y_re, er); end
        checks++; if (y_im !== ei) begin failures++; $display("FAIL shift_fwd_im got %h exp %h", y_im, ei); end
        send_one(64'd64 << 8, 64'd0, 1'b1, lat);
        checks++; if (y_re !== er) begin failures++; $display("FAIL shift_inv_re got %h exp %h", y_re, er); end
        checks++; if (y_im !== eim_inv) begin failures++; $display("FAIL shift_inv_im got %h exp %h", y_im, eim_inv); end
        checks++; if (out_inv !== 1'b1) begin failures++; $display("FAIL shift_inv_out_inv got %b exp 1", out_inv); end
    endtask

    task automatic test_midstream_reset();
        int seen = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b1;
        for (int c = 0; c < 4; c++) begin
            x_re = {$urandom, $urandom}; x_im = {$urandom, $urandom};
            tick();
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got %b exp 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
        checks++; if ({y_re, y_im} !== '0) begin failures++; $display("FAIL midrst_y got %h exp 0", {y_re, y_im}); end
        checks++; if (out_inv !== 1'b0) begin failures++; $display("FAIL midrst_out_inv got %b exp 0", out_inv); end
        in_valid = 1'b0; in_inv = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_partial got %0d valid cycles exp 0", seen); end
    endtask

    task automatic test_backpressure();
        logic [63:0] fr[6], fi[6];
        logic [192:0] exp_v, held;
        int sent = 0, got = 0, cyc = 0, stalls = 0, extra = 0;
        logic was_stalled = 1'b0;
        q.delete();
        for (int i = 0; i < 6; i++) begin
            fr[i] = {$urandom, $urandom};
            fi[i] = {$urandom, $urandom};
        end
        while (got < 6 && cyc < 60) begin
            out_ready = !(cyc >= 5 && cyc <= 8);
            in_valid = sent < 6;
            if (sent < 6) begin x_re = fr[sent]; x_im = fi[sent]; in_inv = sent[0]; end
            @(negedge clk);
            checks++; if (in_ready !== (!out_valid || out_ready)) begin failures++; $display("FAIL bp_in_ready cyc %0d got %b exp %b", cyc, in_ready, !out_valid || out_ready); end
            if (was_stalled) begin
                checks++; if ({out_inv, y_im, y_re} !== held) begin failures++; $display("FAIL bp_hold cyc %0d got %h exp %h", cyc, {out_inv, y_im, y_re}, held); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL bp_extra_frame got %h exp none", {out_inv, y_im, y_re}); end
                else begin
                    exp_v = q.pop_front();
                    if ({out_inv, y_im, y_re} !== exp_v) begin failures++; $display("FAIL bp_frame%0d got %h exp %h", got, {out_inv, y_im, y_re}, exp_v); end
                end
                got++;
            end
            was_stalled = out_valid && !out_ready;
            if (was_stalled) begin held = {out_inv, y_im, y_re}; stalls++; end
            if (in_valid && in_ready) begin q.push_back(model(x_re, x_im, in_inv)); sent++; end
            tick();
            cyc++;
        end
        checks++; if (got !== 6) begin failures++; $display("FAIL bp_count got %0d exp 6", got); end
        checks++; if (stalls !== 4) begin failures++; $display("FAIL bp_stall_cycles got %0d exp 4", stalls); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) extra++;
            tick();
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL bp_duplicate got %0d extra frames exp 0", extra); end
    endtask

    task automatic test_bubbles_mix();
        logic [192:0] exp_v;
        int sent = 0, got = 0, cyc = 0;
        q.delete();
        out_ready = 1'b1;
        while (got < 10 && cyc < 80) begin
            in_valid = (cyc % 2 == 0) && sent < 10;
            x_re = {$urandom, $urandom}; x_im = {$urandom, $urandom}; in_inv = sent[0];
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL mix_extra_frame got %h exp none", {out_inv, y_im, y_re}); end
                else begin
                    exp_v = q.pop_front();
                    if ({out_inv, y_im, y_re} !== exp_v) begin failures++; $display("FAIL mix_frame%0d got %h exp %h", got, {out_inv, y_im, y_re}, exp_v); end
                end
                got++;
            end
            if (in_valid && in_ready) begin q.push_back(model(x_re, x_im, in_inv)); sent++; end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got !== 10) begin failures++; $display("FAIL mix_count got %0d exp 10", got); end
    endtask

    task automatic test_back_to_back();
        logic [192:0] exp_v;
        int sent = 0, got = 0, cyc = 0, first_acc = -1, first_out = -1, last_out = -1, bad = 0;
        q.delete();
        out_ready = 1'b1;
        while (got < 100 && cyc < 400) begin
            in_valid = sent < 100;
            x_re = {$urandom, $urandom}; x_im = {$urandom, $urandom}; in_inv = $urandom_range(0, 1);
            @(negedge clk);
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (q.size() == 0) bad++;
                else begin
                    exp_v = q.pop_front();
                    if ({out_inv, y_im, y_re} !== exp_v) begin
                        bad++;
                        $display("FAIL b2b_frame%0d got %h exp %h", got, {out_inv, y_im, y_re}, exp_v);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                q.push_back(model(x_re, x_im, in_inv));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_data got %0d bad frames exp 0", bad); end
        checks++; if (got !== 100) begin failures++; $display("FAIL b2b_count got %0d exp 100", got); end
        checks++; if (first_out - first_acc !== 4) begin failures++; $display("FAIL b2b_latency got %0d exp 4", first_out - first_acc); end
        checks++; if (last_out - first_out + 1 !== 100) begin failures++; $display("FAIL b2b_contiguous got span %0d exp 100", last_out - first_out + 1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; x_re = '0; x_im = '0;
        test_reset();
        test_impulse();
        test_dc();
        test_shifted_impulse();
        test_midstream_reset();
        test_backpressure();
        test_bubbles_mix();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
